// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift unit: op codes, FSM states and
// the default position of the immediate shamt field.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int SHAMT_LSB_DEFAULT = 6;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves data by up to one step amount,
// using the supplied fill bit for arithmetic right shifts.
module shift_step
    import shift_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STEP_W = 6
) (
    input  logic [XLEN-1:0]   data,
    input  op_e               op,
    input  logic [STEP_W-1:0] step,
    input  logic              fill,
    output logic [XLEN-1:0]   shifted
);

    // A shift by XLEN evaluates to zero, so ROR with step=0 returns data unchanged.
    always_comb begin
        shifted = data;
        case (op)
            OP_SLL:  shifted = data << step;
            OP_SRL:  shifted = data >> step;
            OP_SRA:  shifted = (data >> step) | (fill ? ~({XLEN{1'b1}} >> step) : '0);
            OP_ROR:  shifted = (data >> step) | (data << (XLEN - int'(step)));
            default: shifted = data;
        endcase
    end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle SLL/SRL/SRA unit shifting at most MAX_STEP bits per cycle.
// Define ITER_SHIFT_ROTATE_EN to make op=11 a rotate-right; otherwise op=11 passes rs1 through.
module iter_shift_unit
    import shift_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int SHAMT_W   = 5,
    parameter int SHAMT_LSB = SHAMT_LSB_DEFAULT,
    parameter int MAX_STEP  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic            use_imm,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

`ifdef ITER_SHIFT_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    localparam logic [SHAMT_W:0] MAX_STEP_V = (SHAMT_W+1)'(MAX_STEP);

    state_e             state;
    op_e                op_q;
    logic [XLEN-1:0]    data_q;
    logic [SHAMT_W-1:0] rem_q;
    logic               fill_q;

    logic [SHAMT_W-1:0] shamt;
    logic [SHAMT_W:0]   rem_ext;
    logic [SHAMT_W:0]   step_amt;
    logic [XLEN-1:0]    step_out;
    logic               unused_bits;

    assign shamt       = use_imm ? instr[SHAMT_LSB +: SHAMT_W] : rs2[SHAMT_W-1:0];
    assign rem_ext     = {1'b0, rem_q};
    assign step_amt    = (rem_ext < MAX_STEP_V) ? rem_ext : MAX_STEP_V;
    assign unused_bits = ^{instr, rs2};

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign result    = data_q;

    shift_step #(
        .XLEN   (XLEN),
        .STEP_W (SHAMT_W + 1)
    ) u_step (
        .data    (data_q),
        .op      (op_q),
        .step    (step_amt),
        .fill    (fill_q),
        .shifted (step_out)
    );

    // The sign bit is captured at accept so SRA keeps replicating it across every step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            op_q   <= OP_SLL;
            data_q <= '0;
            rem_q  <= '0;
            fill_q <= 1'b0;
        end else if (flush) begin
            state <= ST_IDLE;
            op_q  <= OP_SLL;
            rem_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_q <= rs1;
                        op_q   <= op_e'(op);
                        fill_q <= rs1[XLEN-1];
                        if (op_e'(op) == OP_ROR && !ROT_EN) begin
                            rem_q <= '0;
                            state <= ST_DONE;
                        end else begin
                            rem_q <= shamt;
                            state <= (shamt != '0) ? ST_BUSY : ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    data_q <= step_out;
                    rem_q  <= rem_q - step_amt[SHAMT_W-1:0];
                    if (rem_ext <= MAX_STEP_V) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed self-checking bench for iter_shift_unit (default parameters).
// Cycle counts are measured from the accept edge: 1 means DONE right after accept.
module tb_iter_shift_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic        use_imm;
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    iter_shift_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .use_imm   (use_imm),
        .instr     (instr),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Present one request for a single accept edge, then count cycles until out_valid.
    task automatic run_req(input logic [1:0] o, input logic ui, input logic [31:0] ins,
                           input logic [31:0] a, input logic [31:0] b, output int cyc);
        @(posedge clk); #1;
        in_valid = 1'b1; op = o; use_imm = ui; instr = ins; rs1 = a; rs2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!out_valid) cyc = 999;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL reset_result got %h want 00000000", result); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_sll();
        int cyc;
        run_req(2'b00, 1'b0, 32'h0, 32'h0000_0001, 32'h0000_0004, cyc);
        checks++; if (cyc !== 2) begin errors++; $display("[TB] FAIL sll_latency got %0d want 2", cyc); end
        checks++; if (result !== 32'h0000_0010) begin errors++; $display("[TB] FAIL sll_result got %h want 00000010", result); end
        consume();
        // Upper rs2 bits must not influence the shift amount (low five bits = 4).
        run_req(2'b00, 1'b0, 32'h0, 32'h0000_0001, 32'hFFFF_FFE4, cyc);
        checks++; if (result !== 32'h0000_0010) begin errors++; $display("[TB] FAIL sll_rs2_high got %h want 00000010", result); end
        consume();
        run_req(2'b00, 1'b1, 32'd31 << 6, 32'h0000_0001, 32'h0, cyc);
        checks++; if (cyc !== 5) begin errors++; $display("[TB] FAIL sll31_latency got %0d want 5", cyc); end
        checks++; if (result !== 32'h8000_0000) begin errors++; $display("[TB] FAIL sll31_result got %h want 80000000", result); end
        consume();
    endtask

    task automatic test_sra();
        int cyc;
        run_req(2'b10, 1'b1, 32'd17 << 6, 32'h8000_0000, 32'h0, cyc);
        checks++; if (cyc !== 4) begin errors++; $display("[TB] FAIL sra_latency got %0d want 4", cyc); end
        checks++; if (result !== 32'hFFFF_C000) begin errors++; $display("[TB] FAIL sra_result got %h want ffffc000", result); end
        consume();
        run_req(2'b01, 1'b0, 32'h0, 32'h0000_AB00, 32'd8, cyc);
        checks++; if (cyc !== 2) begin errors++; $display("[TB] FAIL srl8_latency got %0d want 2", cyc); end
        checks++; if (result !== 32'h0000_00AB) begin errors++; $display("[TB] FAIL srl8_result got %h want 000000ab", result); end
        consume();
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_req(2'b01, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0, cyc);
        checks++; if (cyc !== 1) begin errors++; $display("[TB] FAIL zero_latency got %0d want 1", cyc); end
        checks++; if (result !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL zero_result got %h want deadbeef", result); end
        // Stall the consumer while a second request knocks; it must be ignored.
        in_valid = 1'b1; op = 2'b00; use_imm = 1'b0; rs1 = 32'h1234_5678; rs2 = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (result !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL hold_result[%0d] got %h want deadbeef", i, result); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_in_ready[%0d] got %b want 0", i, in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_out_valid[%0d] got %b want 1", i, out_valid); end
        end
        in_valid = 1'b0;
        consume();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL drain_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_flush();
        int cyc;
        @(posedge clk); #1;
        in_valid = 1'b1; op = 2'b00; use_imm = 1'b1; instr = 32'd31 << 6; rs1 = 32'h0000_0003;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL flush_busy1 got %b want 1", busy); end
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_in_ready got %b want 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy got %b want 0", busy); end
        run_req(2'b01, 1'b0, 32'h0, 32'h0000_0100, 32'd8, cyc);
        checks++; if (cyc !== 2) begin errors++; $display("[TB] FAIL post_flush_latency got %0d want 2", cyc); end
        checks++; if (result !== 32'h0000_0001) begin errors++; $display("[TB] FAIL post_flush_result got %h want 00000001", result); end
        consume();
    endtask

    task automatic test_reserved_op();
        int cyc;
        run_req(2'b11, 1'b0, 32'h0, 32'h0000_00F1, 32'd4, cyc);
`ifdef ITER_SHIFT_ROTATE_EN
        checks++; if (cyc !== 2) begin errors++; $display("[TB] FAIL ror_latency got %0d want 2", cyc); end
        checks++; if (result !== 32'h1000_000F) begin errors++; $display("[TB] FAIL ror_result got %h want 1000000f", result); end
`else
        checks++; if (cyc !== 1) begin errors++; $display("[TB] FAIL op11_latency got %0d want 1", cyc); end
        checks++; if (result !== 32'h0000_00F1) begin errors++; $display("[TB] FAIL op11_result got %h want 000000f1", result); end
`endif
        consume();
    endtask

    task automatic test_async_reset();
        int cyc;
        @(posedge clk); #1;
        in_valid = 1'b1; op = 2'b00; use_imm = 1'b0; rs1 = 32'h0000_0001; rs2 = 32'd31;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async_busy got %b want 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL async_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_out_valid got %b want 0", out_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL async_result got %h want 00000000", result); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_req(2'b00, 1'b0, 32'h0, 32'h0000_0005, 32'd9, cyc);
        checks++; if (cyc !== 3) begin errors++; $display("[TB] FAIL post_reset_latency got %0d want 3", cyc); end
        checks++; if (result !== 32'h0000_0A00) begin errors++; $display("[TB] FAIL post_reset_result got %h want 00000a00", result); end
        consume();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; use_imm = 1'b0;
        instr = 32'h0; rs1 = 32'h0; rs2 = 32'h0; flush = 1'b0; out_ready = 1'b0;
        test_reset();
        test_sll();
        test_sra();
        test_back_to_back();
        test_flush();
        test_reserved_op();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
